// File: rtl/iter_ctrl_if.sv
// Handshake bundle between an iteration controller and the datapath that drives it.
// The master side issues start/limit/step/abort; the slave side reports progress.
interface iter_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] limit;
  logic             step;
  logic             abort;
  logic             busy;
  logic [CNT_W-1:0] count;
  logic             first;
  logic             last;
  logic             done;
  logic             aborted;

  modport master (
    output start, limit, step, abort,
    input  busy, count, first, last, done, aborted
  );

  modport slave (
    input  start, limit, step, abort,
    output busy, count, first, last, done, aborted
  );
endinterface

// File: rtl/iter_ctrl.sv
// Iteration sequencer: runs a 0-based counter up to a latched limit, one step per
// enabled cycle, and reports first/last/done/aborted status to the datapath.
module iter_ctrl #(
  parameter int unsigned CNT_W      = 16,
  parameter bit          DONE_PULSE = 1'b0
) (
  input logic        clk,
  input logic        rst,
  iter_ctrl_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_limit_q;
  logic [CNT_W-1:0] w_last_idx;
  logic             r_done;
  logic             r_aborted;
  logic             w_busy;
  logic             w_accept;
  logic             w_zero_run;
  logic             w_take_abort;
  logic             w_finish;
  logic             w_advance;

  assign w_last_idx = r_limit_q - CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // abort outranks step, so a final-iteration abort never reports done
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_zero_run   = 1'b0;
    w_take_abort = 1'b0;
    w_finish     = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          if (bus.limit == '0) w_zero_run  = 1'b1;
          else                 w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          w_take_abort = 1'b1;
          w_state_nxt  = IDLE;
        end else if (bus.step) begin
          if (r_count == w_last_idx) begin
            w_finish    = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_limit_q <= '0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_aborted <= w_take_abort;
      if (w_accept) begin
        r_limit_q <= bus.limit;
        r_count   <= '0;
        r_done    <= w_zero_run;
      end else if (w_finish) begin
        r_done <= 1'b1;
      end else if (DONE_PULSE) begin
        r_done <= 1'b0;
      end
      if (w_advance) r_count <= r_count + CNT_W'(1);
    end
  end

  always_comb begin
    w_busy      = (r_state == RUN);
    bus.busy    = w_busy;
    bus.count   = r_count;
    bus.first   = w_busy && (r_count == '0);
    bus.last    = w_busy && (r_count == w_last_idx);
    bus.done    = r_done;
    bus.aborted = r_aborted;
  end

endmodule

// File: tb/tb_iter_ctrl.sv
// Directed bench for iter_ctrl: three instances (level done, pulsed done, narrow counter)
// checked every cycle against a reference model through an expectation queue.
module tb_iter_ctrl;

  logic clk;
  logic rst;

  iter_ctrl_if #(.CNT_W(16)) if0 ();
  iter_ctrl_if #(.CNT_W(16)) if1 ();
  iter_ctrl_if #(.CNT_W(4))  if2 ();

  iter_ctrl #(.CNT_W(16), .DONE_PULSE(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  iter_ctrl #(.CNT_W(16), .DONE_PULSE(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  iter_ctrl #(.CNT_W(4),  .DONE_PULSE(1'b0)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic        busy;
    logic [15:0] count;
    logic        first;
    logic        last;
    logic        done;
    logic        aborted;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  bit          m_run  [3];
  logic [15:0] m_cnt  [3];
  logic [15:0] m_lim  [3];
  bit          m_done [3];
  bit          m_ab   [3];
  bit          m_pulse[3] = '{1'b0, 1'b1, 1'b0};

  function automatic void model_step(int s, bit r, bit st, logic [15:0] lm, bit sp, bit ab);
    logic [15:0] l;
    l = (s == 2) ? (lm & 16'h000F) : lm;
    if (r) begin
      m_run[s] = 0; m_cnt[s] = '0; m_lim[s] = '0; m_done[s] = 0; m_ab[s] = 0;
    end else if (!m_run[s]) begin
      m_ab[s] = 0;
      if (st) begin
        m_lim[s] = l;
        m_cnt[s] = '0;
        if (l == 16'd0) m_done[s] = 1;
        else begin m_run[s] = 1; m_done[s] = 0; end
      end else if (m_pulse[s]) begin
        m_done[s] = 0;
      end
    end else begin
      m_ab[s] = 0;
      if (ab) begin
        m_run[s] = 0; m_ab[s] = 1;
      end else if (sp) begin
        if (m_cnt[s] + 16'd1 == m_lim[s]) begin m_run[s] = 0; m_done[s] = 1; end
        else m_cnt[s] = m_cnt[s] + 16'd1;
      end
    end
  endfunction

  function automatic exp_t actual(int s);
    exp_t a;
    a.sel = s;
    case (s)
      0: begin a.busy = if0.busy; a.count = if0.count; a.first = if0.first;
               a.last = if0.last; a.done = if0.done; a.aborted = if0.aborted; end
      1: begin a.busy = if1.busy; a.count = if1.count; a.first = if1.first;
               a.last = if1.last; a.done = if1.done; a.aborted = if1.aborted; end
      default: begin a.busy = if2.busy; a.count = {12'd0, if2.count}; a.first = if2.first;
               a.last = if2.last; a.done = if2.done; a.aborted = if2.aborted; end
    endcase
    return a;
  endfunction

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(int sel, bit st, logic [15:0] lm, bit sp, bit ab);
    if0.start = (sel == 0) && st; if0.limit = (sel == 0) ? lm : 16'd0;
    if0.step  = (sel == 0) && sp; if0.abort = (sel == 0) && ab;
    if1.start = (sel == 1) && st; if1.limit = (sel == 1) ? lm : 16'd0;
    if1.step  = (sel == 1) && sp; if1.abort = (sel == 1) && ab;
    if2.start = (sel == 2) && st; if2.limit = (sel == 2) ? lm[3:0] : 4'd0;
    if2.step  = (sel == 2) && sp; if2.abort = (sel == 2) && ab;
  endtask

  // One clock: drive, predict all three instances, then compare after the edge.
  task automatic cyc(int sel, bit st, logic [15:0] lm, bit sp, bit ab);
    exp_t e;
    exp_t a;
    drive(sel, st, lm, sp, ab);
    for (int s = 0; s < 3; s++) begin
      if (s == sel) model_step(s, rst, st, lm, sp, ab);
      else          model_step(s, rst, 1'b0, 16'd0, 1'b0, 1'b0);
      e.sel = s; e.busy = m_run[s]; e.count = m_cnt[s];
      e.first = m_run[s] && (m_cnt[s] == 16'd0);
      e.last  = m_run[s] && (m_cnt[s] == m_lim[s] - 16'd1);
      e.done = m_done[s]; e.aborted = m_ab[s];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = actual(e.sel);
      chk($sformatf("u%0d.busy", e.sel),    32'(a.busy),    32'(e.busy));
      chk($sformatf("u%0d.count", e.sel),   32'(a.count),   32'(e.count));
      chk($sformatf("u%0d.first", e.sel),   32'(a.first),   32'(e.first));
      chk($sformatf("u%0d.last", e.sel),    32'(a.last),    32'(e.last));
      chk($sformatf("u%0d.done", e.sel),    32'(a.done),    32'(e.done));
      chk($sformatf("u%0d.aborted", e.sel), 32'(a.aborted), 32'(e.aborted));
    end
  endtask

  int busy_cnt;

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 16'd0, 1'b0, 1'b0);
    cyc(2, 1'b1, 16'd9, 1'b1, 1'b0);
    cyc(0, 1'b1, 16'd3, 1'b1, 1'b0);
    rst = 1'b0;
    chk("reset_busy", 32'(if0.busy), 0);
    chk("reset_done", 32'(if0.done), 0);

    // limit 5, step held high
    busy_cnt = 0;
    cyc(0, 1'b1, 16'd5, 1'b1, 1'b0);
    busy_cnt += int'(if0.busy);
    chk("first_at_0", 32'(if0.first), 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1'b0, 16'd0, 1'b1, 1'b0);
      busy_cnt += int'(if0.busy);
      if (i == 3) chk("last_at_4", 32'(if0.last), 1);
    end
    chk("busy_len", 32'(busy_cnt), 5);
    chk("done_latency", 32'(if0.done), 1);
    chk("hold_count", 32'(if0.count), 4);
    cyc(0, 1'b0, 16'd0, 1'b0, 1'b0);
    cyc(0, 1'b0, 16'd0, 1'b0, 1'b0);
    chk("done_held", 32'(if0.done), 1);

    // limit 4 with stalls
    cyc(0, 1'b1, 16'd4, 1'b0, 1'b0);
    chk("done_cleared", 32'(if0.done), 0);
    for (int i = 0; i < 8; i++) cyc(0, 1'b0, 16'd0, (i % 2) == 0, 1'b0);
    chk("stall_done", 32'(if0.done), 1);

    // abort at count 3; start+abort in IDLE is accepted; start/limit in RUN ignored
    cyc(0, 1'b1, 16'd6, 1'b0, 1'b1);
    chk("start_with_abort", 32'(if0.busy), 1);
    cyc(0, 1'b1, 16'd2, 1'b1, 1'b0);
    cyc(0, 1'b0, 16'd0, 1'b1, 1'b0);
    cyc(0, 1'b0, 16'd0, 1'b1, 1'b0);
    chk("cnt_before_abort", 32'(if0.count), 3);
    cyc(0, 1'b0, 16'd6, 1'b0, 1'b1);
    chk("abort1_pulse", 32'(if0.aborted), 1);
    chk("abort1_done", 32'(if0.done), 0);
    chk("abort1_count", 32'(if0.count), 3);
    cyc(0, 1'b1, 16'd3, 1'b1, 1'b0);
    chk("restart_after_abort", 32'(if0.busy), 1);
    cyc(0, 1'b0, 16'd0, 1'b1, 1'b0);
    cyc(0, 1'b0, 16'd0, 1'b1, 1'b0);
    cyc(0, 1'b0, 16'd0, 1'b1, 1'b1);
    chk("abort2_pulse", 32'(if0.aborted), 1);
    chk("abort2_done", 32'(if0.done), 0);
    cyc(0, 1'b0, 16'd0, 1'b0, 1'b1);
    chk("abort_idle_ignored", 32'(if0.aborted), 0);

    // zero-length run
    cyc(0, 1'b1, 16'd0, 1'b1, 1'b0);
    chk("zero_done", 32'(if0.done), 1);
    chk("zero_busy", 32'(if0.busy), 0);
    cyc(0, 1'b0, 16'd0, 1'b0, 1'b0);

    // pulsed done with back-to-back start
    cyc(1, 1'b1, 16'd2, 1'b0, 1'b0);
    cyc(1, 1'b0, 16'd0, 1'b1, 1'b0);
    cyc(1, 1'b0, 16'd0, 1'b1, 1'b0);
    chk("pulse_done", 32'(if1.done), 1);
    cyc(1, 1'b1, 16'd2, 1'b1, 1'b0);
    chk("b2b_done_clear", 32'(if1.done), 0);
    chk("b2b_count", 32'(if1.count), 0);
    cyc(1, 1'b0, 16'd0, 1'b1, 1'b0);
    cyc(1, 1'b0, 16'd0, 1'b1, 1'b0);
    cyc(1, 1'b0, 16'd0, 1'b0, 1'b0);
    chk("pulse_one_cycle", 32'(if1.done), 0);

    // narrow counter: full run without wrap, then reset mid-run
    cyc(2, 1'b1, 16'd15, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) cyc(2, 1'b0, 16'd0, 1'b1, 1'b0);
    chk("narrow_max", 32'(if2.count), 14);
    chk("narrow_last", 32'(if2.last), 1);
    cyc(2, 1'b0, 16'd0, 1'b1, 1'b0);
    chk("narrow_done", 32'(if2.done), 1);
    chk("narrow_nowrap", 32'(if2.count), 14);
    cyc(2, 1'b1, 16'd15, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(2, 1'b0, 16'd0, 1'b1, 1'b0);
    chk("narrow_mid", 32'(if2.count), 7);
    rst = 1'b1;
    cyc(2, 1'b0, 16'd0, 1'b1, 1'b1);
    rst = 1'b0;
    chk("rst_mid_count", 32'(if2.count), 0);
    chk("rst_mid_done", 32'(if2.done), 0);
    chk("rst_mid_aborted", 32'(if2.aborted), 0);
    cyc(2, 1'b0, 16'd0, 1'b0, 1'b0);

    // start accepted on the first edge after reset release
    rst = 1'b1;
    cyc(0, 1'b1, 16'd1, 1'b1, 1'b0);
    rst = 1'b0;
    cyc(0, 1'b1, 16'd1, 1'b0, 1'b0);
    chk("post_rst_start", 32'(if0.busy), 1);
    cyc(0, 1'b0, 16'd0, 1'b1, 1'b0);
    chk("post_rst_done", 32'(if0.done), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
